// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, register-index width and
// the writeback control bit positions used by both EX/MEM and MEM/WB.
package mips_pkg;

  localparam int DATA_W          = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/regfile_core.sv
// Register storage with two asynchronous read ports and one synchronous write
// port; index 0 is hardwired to zero.
module regfile_core
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  // Storage update: synchronous clear, then the single write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (waddr != {ADDR_W{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Asynchronous read ports; index 0 never reaches the array.
  always_comb begin
    if (raddr1 == {ADDR_W{1'b0}}) begin
      rdata1 = {DATA_W{1'b0}};
    end else begin
      rdata1 = regs_r[raddr1];
    end
    if (raddr2 == {ADDR_W{1'b0}}) begin
      rdata2 = {DATA_W{1'b0}};
    end else begin
      rdata2 = regs_r[raddr2];
    end
  end

endmodule : regfile_core

// File: rtl/wb_regfile.sv
// Writeback stage: selects memory/ALU data, commits it to the register file and
// counts retired writebacks. Define WB_FWD_EN for same-cycle write-through reads.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [1:0]                     WBreg,
  input  logic [DATA_W-1:0]              Memreg,
  input  logic [DATA_W-1:0]              ALUreg,
  input  logic [mips_pkg::REG_ADDR_W-1:0] RegRDreg,
  input  logic [mips_pkg::REG_ADDR_W-1:0] ReadReg1,
  input  logic [mips_pkg::REG_ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0]              ReadData1,
  output logic [DATA_W-1:0]              ReadData2,
  output logic [DATA_W-1:0]              WriteData,
  output logic [CNT_W-1:0]               wb_count
);

  import mips_pkg::*;

  logic              commit_s;
  logic [DATA_W-1:0] write_data_s;
  logic [DATA_W-1:0] core_rd1_s;
  logic [DATA_W-1:0] core_rd2_s;
  logic [CNT_W-1:0]  wb_count_r;

  // Writeback mux and commit qualification; reset suppresses any commit.
  always_comb begin
    if (WBreg[WB_MEMTOREG_BIT]) begin
      write_data_s = Memreg;
    end else begin
      write_data_s = ALUreg;
    end
    if (WBreg[WB_REGWRITE_BIT] && (RegRDreg != REG_ZERO) && !reset) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  regfile_core #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (REG_ADDR_W)
  ) u_core (
    .clock  (clock),
    .reset  (reset),
    .we     (commit_s),
    .waddr  (RegRDreg),
    .wdata  (write_data_s),
    .raddr1 (ReadReg1),
    .raddr2 (ReadReg2),
    .rdata1 (core_rd1_s),
    .rdata2 (core_rd2_s)
  );

`ifdef WB_FWD_EN
  // Write-through bypass: a committing write is visible to reads in the same cycle.
  always_comb begin
    if (commit_s && (ReadReg1 == RegRDreg)) begin
      ReadData1 = write_data_s;
    end else begin
      ReadData1 = core_rd1_s;
    end
    if (commit_s && (ReadReg2 == RegRDreg)) begin
      ReadData2 = write_data_s;
    end else begin
      ReadData2 = core_rd2_s;
    end
  end
`else
  // No bypass: reads see the array only, new data appears after the commit edge.
  always_comb begin
    ReadData1 = core_rd1_s;
    ReadData2 = core_rd2_s;
  end
`endif

  // Retired-writeback counter, wraps silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_count_r <= {CNT_W{1'b0}};
    end else if (commit_s) begin
      wb_count_r <= wb_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign WriteData = write_data_s;
  assign wb_count  = wb_count_r;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a register-array model compared every
// cycle plus directed literal checks. Counter narrowed to 4 bits to reach wrap.
module tb_wb_regfile;

  localparam int CW = 4;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    WBreg;
  logic [31:0]   Memreg, ALUreg;
  logic [4:0]    RegRDreg, ReadReg1, ReadReg2;
  logic [31:0]   ReadData1, ReadData2, WriteData;
  logic [CW-1:0] wb_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [31:0] model_regs [32];
  int          model_cnt;

  wb_regfile #(.DATA_W(32), .NUM_REGS(32), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .WBreg(WBreg), .Memreg(Memreg), .ALUreg(ALUreg),
    .RegRDreg(RegRDreg), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteData(WriteData),
    .wb_count(wb_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wd();
    return WBreg[0] ? Memreg : ALUreg;
  endfunction

  function automatic bit exp_commit();
    return (WBreg[1] === 1'b1) && (RegRDreg != 5'd0) && (reset === 1'b0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (FWD && exp_commit() && (idx == RegRDreg)) return exp_wd();
    return model_regs[idx];
  endfunction

  // Model: registers and counter as the architectural rules define them.
  always @(posedge clock) begin
    if (reset === 1'b1) begin
      for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
      model_cnt <= 0;
    end else if (exp_commit()) begin
      model_regs[RegRDreg] <= exp_wd();
      model_cnt <= model_cnt + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_wdata", WriteData, exp_wd());
      check("model_rd1", ReadData1, exp_read(ReadReg1));
      check("model_rd2", ReadData2, exp_read(ReadReg2));
      check("model_cnt", {28'd0, wb_count}, {28'd0, 4'(model_cnt % 16)});
    end
  end

  task automatic drive(input logic [1:0] wb, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic rst);
    @(posedge clock);
    #1;
    WBreg = wb; Memreg = mem; ALUreg = alu; RegRDreg = rd;
    ReadReg1 = r1; ReadReg2 = r2; reset = rst;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; WBreg = 2'b10; Memreg = 32'd0; ALUreg = 32'h77; RegRDreg = 5'd6;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;

    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31, 1'b0);
    cmp_en = 1'b1;
    settle();
    check("reset_rd1", ReadData1, 32'd0);
    check("reset_rd2", ReadData2, 32'd0);
    check("reset_cnt", {28'd0, wb_count}, 32'd0);

    drive(2'b10, 32'd0, 32'h1234_5678, 5'd8, 5'd0, 5'd0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd8, 5'd0, 1'b0);
    settle();
    check("alu_wb_rd1", ReadData1, 32'h1234_5678);
    check("alu_wb_cnt", {28'd0, wb_count}, 32'd1);

    drive(2'b11, 32'hDEAD_BEEF, 32'h1, 5'd9, 5'd0, 5'd0, 1'b0);
    settle();
    check("mem_wdata", WriteData, 32'hDEAD_BEEF);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd9, 5'd8, 1'b0);
    settle();
    check("mem_wb_rd1", ReadData1, 32'hDEAD_BEEF);
    check("mem_wb_cnt", {28'd0, wb_count}, 32'd2);

    drive(2'b10, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b0);
    settle();
    check("zero_wdata", WriteData, 32'hFFFF_FFFF);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    settle();
    check("zero_rd1", ReadData1, 32'd0);
    check("zero_cnt", {28'd0, wb_count}, 32'd2);

    drive(2'b01, 32'h55, 32'h66, 5'd3, 5'd3, 5'd3, 1'b0);
    settle();
    check("nowr_wdata", WriteData, 32'h55);
    check("nowr_same_rd1", ReadData1, 32'd0);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3, 1'b0);
    settle();
    check("nowr_rd2", ReadData2, 32'd0);
    check("nowr_cnt", {28'd0, wb_count}, 32'd2);

    drive(2'b10, 32'd0, 32'hA, 5'd4, 5'd0, 5'd0, 1'b0);
    drive(2'b10, 32'd0, 32'hB, 5'd4, 5'd0, 5'd4, 1'b0);
    settle();
    check("rw_same_rd2", ReadData2, FWD ? 32'hB : 32'hA);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd4, 5'd4, 1'b0);
    settle();
    check("rw_next_rd1", ReadData1, 32'hB);
    check("rw_next_rd2", ReadData2, 32'hB);
    check("rw_cnt", {28'd0, wb_count}, 32'd4);

    drive(2'b10, 32'd0, 32'h77, 5'd6, 5'd6, 5'd4, 1'b1);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd6, 5'd4, 1'b0);
    settle();
    check("rstcol_rd1", ReadData1, 32'd0);
    check("rstcol_rd2", ReadData2, 32'd0);
    check("rstcol_cnt", {28'd0, wb_count}, 32'd0);

    for (int i = 1; i <= 17; i++) begin
      drive(2'b10, 32'd0, 32'(i), 5'((i % 31) + 1), 5'((i % 31) + 1), 5'd2, 1'b0);
      if (i == 17) begin
        settle();
        check("wrap16_cnt", {28'd0, wb_count}, 32'd0);
      end
    end
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd17, 5'd2, 1'b0);
    settle();
    check("wrap17_cnt", {28'd0, wb_count}, 32'd1);
    check("wrap_rd1", ReadData1, 32'd16);
    check("wrap_rd2", ReadData2, 32'd1);

    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd9, 5'd9, 1'b0);
    settle();
    check("dual_rd1", ReadData1, 32'd8);
    check("dual_rd2", ReadData2, 32'd8);

    @(posedge clock);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_regfile
